// File: rtl/nonce_sampler.sv
// Rejection-sampling nonce requester: drives the PRNG start, masks each word to QBITS
// and accepts the first candidate in [1, q-1]. Optional macro: NONCE_ZEROIZE_EN.
module nonce_sampler #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned QBITS     = 256,
  parameter int unsigned MAX_TRIES = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] q,
  output logic             prng_start,
  input  logic [WIDTH-1:0] prng_data,
  input  logic             prng_valid,
  output logic [WIDTH-1:0] k,
  output logic             k_valid,
  output logic             busy,
  output logic             fail,
  output logic [3:0]       tries
);

  localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} >> (WIDTH - QBITS);
  localparam logic [3:0]       MAXT = 4'(MAX_TRIES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_FAIL} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_q, r_cand, r_k;
  logic             r_k_valid, r_fail;
  logic [3:0]       r_tries;
  logic             w_accept, w_last, w_q_small;

  assign w_accept  = (r_cand != '0) && (r_cand < r_q);
  assign w_last    = (r_tries + 4'd1) == MAXT;
  assign w_q_small = (q[WIDTH-1:1] == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req) w_next = w_q_small ? S_FAIL : S_FILL;
      S_FILL:  if (prng_valid) w_next = S_CHECK;
      S_CHECK: w_next = w_accept ? S_IDLE : (w_last ? S_FAIL : S_FILL);
      S_FAIL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_cand    <= '0;
      r_k       <= '0;
      r_k_valid <= 1'b0;
      r_fail    <= 1'b0;
      r_tries   <= '0;
    end else begin
      r_k_valid <= 1'b0;
`ifdef NONCE_ZEROIZE_EN
      // k is only guaranteed during the k_valid cycle; wipe it right after
      if (r_k_valid) r_k <= '0;
`endif
      case (r_state)
        S_IDLE: if (req) begin
          r_q     <= q;
          r_tries <= '0;
          r_fail  <= 1'b0;
        end
        S_FILL: if (prng_valid) r_cand <= prng_data & MASK;
        S_CHECK: begin
          if (w_accept) begin
            r_k       <= r_cand;
            r_k_valid <= 1'b1;
          end else begin
            r_tries <= w_last ? MAXT : r_tries + 4'd1;
          end
`ifdef NONCE_ZEROIZE_EN
          r_cand <= '0;
`endif
        end
        S_FAIL: r_fail <= 1'b1;
        default: ;
      endcase
    end
  end

  assign prng_start = (r_state == S_FILL);
  assign busy       = (r_state != S_IDLE);
  assign k          = r_k;
  assign k_valid    = r_k_valid;
  assign fail       = r_fail;
  assign tries      = r_tries;

endmodule

// File: doc/nonce_sampler.md
Name: nonce_sampler

Overview:
- Consumer/requester end of the 256-bit PRNG interface: drives the generator's start, collects its valid-qualified 256-bit word, and uses rejection sampling to produce a Schnorr nonce k in [1, q-1].
- Sits between the 256-bit PRNG and the signing datapath.
- Replaces ad-hoc start/valid handling in the signer.

Parameters:
- WIDTH, 256: nonce/PRNG word width in bits.
- QBITS, 256: bit-length of the group order; candidates are masked to the low QBITS bits (1..WIDTH).
- MAX_TRIES, 15: rejected candidates allowed before failure (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request a new nonce; sampled only in IDLE.
- q  input  WIDTH  group order; latched on accepted req.
- prng_start  output  1  held high while a PRNG word is wanted.
- prng_data  input  WIDTH  PRNG 256-bit output.
- prng_valid  input  1  one-cycle pulse: prng_data holds a fresh word.
- k  output  WIDTH  accepted nonce.
- k_valid  output  1  one-cycle pulse: k is new.
- busy  output  1  high in any state other than IDLE.
- fail  output  1  sticky failure flag; cleared by the next accepted req.
- tries  output  4  rejections counted for the current request.

Behaviour:
- Reset:
  - Clock-synchronous, active-high: state=IDLE; k=0, k_valid=0, prng_start=0, busy=0, fail=0, tries=0; internal q_r=0, cand=0.
  - Asserting rst in any state aborts the operation the same cycle with no k_valid pulse.
- States: IDLE, FILL, CHECK, FAIL.
- IDLE:
  - On req=1: latch q_r<=q, tries<=0, fail<=0.
  - If q<2: go to FAIL (no valid nonce exists).
  - Otherwise: go to FILL with prng_start=1 from the next cycle.
- FILL:
  - prng_start held at 1 continuously. The PRNG needs 8 consecutive start cycles per word, so start must never drop in FILL.
  - On prng_valid=1: cand<=prng_data & mask, where mask = low QBITS bits set; go to CHECK.
  - prng_start is 0 in CHECK.
- CHECK (1 cycle): accept iff cand!=0 and cand<q_r, unsigned WIDTH-bit compare.
  - Accept: k<=cand, k_valid=1 for exactly 1 cycle, go to IDLE.
  - Reject, tries+1==MAX_TRIES: tries<=MAX_TRIES, go to FAIL.
  - Reject otherwise: tries<=tries+1, go to FILL.
- FAIL (1 cycle): fail<=1, go to IDLE. fail stays high until the next accepted req.
- Latency, no rejection: req at cycle 0; prng_start high from cycle 1; k_valid one cycle after CHECK, where CHECK follows the prng_valid cycle.
- req while busy is ignored; no queuing.
- prng_valid outside FILL is ignored.
- q changes after latch have no effect.
- k holds its value between requests (see feature).
- Edge cases:
  - q=2: only cand=1 is accepted.
  - QBITS=WIDTH: mask is all ones.

Optional Feature:
- Macro: NONCE_ZEROIZE_EN.
- Defined:
  - k is cleared to 0 on the cycle after the k_valid pulse.
  - cand is cleared to 0 on every reject and on every accept. No secret material remains in registers.
  - The consumer must capture k on k_valid.
- Undefined:
  - k holds the last accepted nonce until the next accept or reset.
  - cand keeps its last value.

Test Plan:
- q=0xFFFF...FF, QBITS=256; model PRNG returns 0x1234 (zero-extended) after 8 start cycles -> single k_valid with k=0x1234, tries=0, fail=0, busy low the cycle after.
- q=0x100, QBITS=256; model returns 0x200, then 0x0, then 0x55 -> two rejections, tries=2, k=0x55, exactly one k_valid pulse.
- MAX_TRIES=3; model always returns 0 -> no k_valid; fail=1 after the third CHECK; tries=3; next req clears fail.
- req with q=1 -> FAIL next cycle, fail=1, prng_start never asserted.
- rst asserted mid-FILL (start high 4 cycles) -> next cycle prng_start=0, busy=0, k unchanged at 0; later prng_valid ignored.
- With NONCE_ZEROIZE_EN: accept k=0x77 -> k=0x77 during k_valid, k=0 one cycle later. Without the macro: k stays 0x77.
